// File: rtl/mod_counter_fsm.sv
// Parametrised modulo-N sequence counter: enable, up/down, wrap or saturate,
// synchronous clear/load, registered wrap pulse and combinational bound decodes.
module mod_counter_fsm #(
  parameter int unsigned       WIDTH       = 2,
  parameter longint unsigned   MAX_COUNT   = 3,
  parameter longint unsigned   RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "mod_counter_fsm: WIDTH must be in 1..32");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "mod_counter_fsm: MAX_COUNT must be in 1..2**WIDTH-1");
  end
  if (RESET_VALUE > MAX_COUNT) begin : g_bad_rst
    $fatal(1, "mod_counter_fsm: RESET_VALUE must not exceed MAX_COUNT");
  end

  localparam logic [WIDTH:0]   MAX_W = MAX_COUNT[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_N = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_N = RESET_VALUE[WIDTH-1:0];

  // One extra bit so count+1 at MAX_COUNT = 2**WIDTH-1 cannot overflow.
  logic [WIDTH:0] cnt_x;
  assign cnt_x = {1'b0, count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_N;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if ({1'b0, load_val} > MAX_W) count <= MAX_N;
        else                          count <= load_val;
      end else if (en) begin
        if (up_dn) begin
          if (cnt_x < MAX_W) begin
            count <= WIDTH'(cnt_x + (WIDTH+1)'(1));
          end else if (!sat_mode) begin
            count <= '0;
            wrap  <= 1'b1;
          end
        end else begin
          if (cnt_x != '0) begin
            count <= WIDTH'(cnt_x - (WIDTH+1)'(1));
          end else if (!sat_mode) begin
            count <= MAX_N;
            wrap  <= 1'b1;
          end
        end
      end
    end
  end

  assign at_max = (cnt_x == MAX_W);
  assign at_min = (count == '0);

  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n) (cnt_x <= MAX_W))
    else $error("mod_counter_fsm: count exceeds MAX_COUNT");

endmodule
